// File: rtl/bsg_mcl_tx_arbiter_if.sv
// rtl/bsg_mcl_tx_arbiter_if.sv - TX FIFO to outbound link handshake bundle for the packet arbiter
interface bsg_mcl_tx_arbiter_if #(
  parameter int num_fifos_p  = 2,
  parameter int data_width_p = 32
);
  localparam int id_width_lp = (num_fifos_p > 1) ? $clog2(num_fifos_p) : 1;

  logic [num_fifos_p-1:0]                   en_i;
  logic [num_fifos_p-1:0][data_width_p-1:0] fifo_data_i;
  logic [num_fifos_p-1:0]                   fifo_v_i;
  logic [num_fifos_p-1:0]                   fifo_yumi_o;
  logic [data_width_p-1:0]                  data_o;
  logic                                     v_o;
  logic                                     ready_i;
  logic [id_width_lp-1:0]                   src_id_o;
  logic                                     last_o;
  logic                                     busy_o;
  logic [num_fifos_p-1:0]                   clear_isr_tc_i;
  logic [num_fifos_p-1:0]                   isr_tc_o;

  modport master (
    input  en_i, fifo_data_i, fifo_v_i, ready_i, clear_isr_tc_i,
    output fifo_yumi_o, data_o, v_o, src_id_o, last_o, busy_o, isr_tc_o
  );

  modport slave (
    output en_i, fifo_data_i, fifo_v_i, ready_i, clear_isr_tc_i,
    input  fifo_yumi_o, data_o, v_o, src_id_o, last_o, busy_o, isr_tc_o
  );
endinterface

// File: rtl/bsg_mcl_tx_arbiter.sv
// rtl/bsg_mcl_tx_arbiter.sv - packet-granular round-robin arbiter over host TX FIFOs with TC flags
module bsg_mcl_tx_arbiter #(
  parameter int num_fifos_p  = 2,
  parameter int pkt_words_p  = 4,
  parameter int data_width_p = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_mcl_tx_arbiter_if.master  bus
);
  localparam int id_width_lp  = (num_fifos_p > 1) ? $clog2(num_fifos_p) : 1;
  localparam int cnt_width_lp = $clog2(pkt_words_p);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp   = cnt_width_lp'(pkt_words_p - 1);
  localparam logic [id_width_lp-1:0]  init_grant_lp = id_width_lp'(num_fifos_p - 1);

  typedef enum logic {e_idle, e_xfer} state_e;

  state_e                   state_r, state_n;
  logic [id_width_lp-1:0]   grant_r, grant_n;
  logic [id_width_lp-1:0]   last_grant_r, last_grant_n;
  logic [cnt_width_lp-1:0]  word_cnt_r, word_cnt_n;
  logic [num_fifos_p-1:0]   isr_tc_r, isr_tc_n, tc_set;

  logic [num_fifos_p-1:0]   req;
  logic                     pick_v;
  logic [id_width_lp-1:0]   pick_id;
  logic [id_width_lp-1:0]   cand;
  logic                     handshake;

  assign req = bus.fifo_v_i & bus.en_i;

  // Search starts just past the last packet's owner so every requester gets a turn.
  always_comb begin
    pick_v  = 1'b0;
    pick_id = '0;
    cand    = '0;
    for (int k = 1; k <= num_fifos_p; k++) begin
      cand = id_width_lp'((int'(last_grant_r) + k) % num_fifos_p);
      if (!pick_v && req[cand]) begin
        pick_v  = 1'b1;
        pick_id = cand;
      end
    end
  end

  always_comb begin
    state_n          = state_r;
    grant_n          = grant_r;
    last_grant_n     = last_grant_r;
    word_cnt_n       = word_cnt_r;
    tc_set           = '0;
    handshake        = 1'b0;
    bus.v_o          = 1'b0;
    bus.fifo_yumi_o  = '0;
    bus.busy_o       = 1'b0;
    bus.last_o       = 1'b0;
    bus.src_id_o     = grant_r;
    bus.data_o       = bus.fifo_data_i[grant_r];

    case (state_r)
      e_idle: begin
        if (pick_v) begin
          grant_n = pick_id;
          state_n = e_xfer;
        end
      end
      e_xfer: begin
        bus.busy_o = 1'b1;
        bus.v_o    = bus.fifo_v_i[grant_r];
        bus.last_o = (word_cnt_r == last_cnt_lp);
        handshake  = bus.v_o & bus.ready_i;
        bus.fifo_yumi_o[grant_r] = handshake;
        if (handshake) begin
          if (word_cnt_r == last_cnt_lp) begin
            word_cnt_n      = '0;
            last_grant_n    = grant_r;
            tc_set[grant_r] = 1'b1;
            state_n         = e_idle;
          end else begin
            word_cnt_n = word_cnt_r + cnt_width_lp'(1);
          end
        end
      end
      default: state_n = e_idle;
    endcase

    // A completion landing on the same cycle as its clear must stay visible.
    isr_tc_n = (isr_tc_r & ~bus.clear_isr_tc_i) | tc_set;
  end

  assign bus.isr_tc_o = isr_tc_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= e_idle;
      grant_r      <= '0;
      last_grant_r <= init_grant_lp;
      word_cnt_r   <= '0;
      isr_tc_r     <= '0;
    end else begin
      state_r      <= state_n;
      grant_r      <= grant_n;
      last_grant_r <= last_grant_n;
      word_cnt_r   <= word_cnt_n;
      isr_tc_r     <= isr_tc_n;
    end
  end
endmodule

// File: tb/tb_bsg_mcl_tx_arbiter.sv
// tb/tb_bsg_mcl_tx_arbiter.sv - self-checking bench for bsg_mcl_tx_arbiter
`timescale 1ns/1ps
module tb_bsg_mcl_tx_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bsg_mcl_tx_arbiter_if #(.num_fifos_p(2), .data_width_p(32)) bus ();

  bsg_mcl_tx_arbiter #(.num_fifos_p(2), .pkt_words_p(4), .data_width_p(32)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  gate;
    logic        rdy;
    logic [1:0]  clr;
    logic        ev;
    logic [1:0]  eyumi;
    logic        elast;
    logic        ebusy;
    logic        esrc;
    logic [1:0]  etc;
    logic [31:0] edata;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        src;
    logic        last;
    int          cyc;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        rst_n = 1'b0;
  logic [1:0]  en = 2'b11;
  logic [1:0]  gate = 2'b00;
  logic        rdy = 1'b1;
  logic [1:0]  clr = 2'b00;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  ent_t        lg[$];
  vec_t        vt[15];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    reset_n               = rst_n;
    bus.en_i              = en;
    bus.ready_i           = rdy;
    bus.clear_isr_tc_i    = clr;
    bus.fifo_v_i[0]       = gate[0] && (q0.size() != 0);
    bus.fifo_v_i[1]       = gate[1] && (q1.size() != 0);
    bus.fifo_data_i[0]    = (q0.size() != 0) ? q0[0] : 32'h0;
    bus.fifo_data_i[1]    = (q1.size() != 0) ? q1[0] : 32'h0;
    #1;
  endtask

  task automatic tick_b();
    logic p0, p1;
    ent_t e;
    if (bus.v_o && bus.ready_i) begin
      e.d = bus.data_o; e.src = bus.src_id_o[0]; e.last = bus.last_o; e.cyc = cyc;
      lg.push_back(e);
    end
    p0 = bus.fifo_yumi_o[0];
    p1 = bus.fifo_yumi_o[1];
    @(posedge clk);
    if (p0 && q0.size() != 0) void'(q0.pop_front());
    if (p1 && q1.size() != 0) void'(q1.pop_front());
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; gate = 2'b00; en = 2'b11; rdy = 1'b1; clr = 2'b00;
    tick_a(); tick_b(); tick_a(); tick_b();
    rst_n = 1'b1;
    q0.delete(); q1.delete(); lg.delete();
    cyc = 0;
  endtask

  initial begin
    //         en     gate   rdy   clr    v     yumi   last  busy  src   tc     data
    vt[0]  = '{2'b11, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
    vt[1]  = '{2'b11, 2'b10, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 32'hA0};
    vt[2]  = '{2'b11, 2'b10, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 32'hA1};
    vt[3]  = '{2'b11, 2'b10, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 32'hA2};
    vt[4]  = '{2'b11, 2'b10, 1'b1, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 32'hA3};
    vt[5]  = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0};
    vt[6]  = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 32'hB0};
    vt[7]  = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 32'hB1};
    vt[8]  = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 32'hB1};
    vt[9]  = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 32'hB1};
    vt[10] = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 32'hB2};
    vt[11] = '{2'b11, 2'b11, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 2'b10, 32'hB3};
    vt[12] = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 32'h0};
    vt[13] = '{2'b11, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 32'h0};
    vt[14] = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};

    // Single requester, backpressure and TC set/clear race.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q1.push_back(32'hA0 + 32'(i));
      q0.push_back(32'hB0 + 32'(i));
    end
    for (int i = 0; i < 15; i++) begin
      en = vt[i].en; gate = vt[i].gate; rdy = vt[i].rdy; clr = vt[i].clr;
      tick_a();
      check("v", i, 32'(bus.v_o), 32'(vt[i].ev));
      check("yumi", i, 32'(bus.fifo_yumi_o), 32'(vt[i].eyumi));
      check("last", i, 32'(bus.last_o), 32'(vt[i].elast));
      check("busy", i, 32'(bus.busy_o), 32'(vt[i].ebusy));
      check("src", i, 32'(bus.src_id_o), 32'(vt[i].esrc));
      check("tc", i, 32'(bus.isr_tc_o), 32'(vt[i].etc));
      if (vt[i].ev) check("data", i, bus.data_o, vt[i].edata);
      tick_b();
    end
    check("q0_left", 0, 32'(q0.size()), 32'd0);
    check("q1_left", 0, 32'(q1.size()), 32'd0);
    check("words", 0, 32'(lg.size()), 32'd8);

    // Contention: packets alternate F0,F1,F0,F1 with one bubble between them.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(32'hC0 + 32'(i));
      q1.push_back(32'hD0 + 32'(i));
    end
    gate = 2'b11;
    for (int t = 0; t < 60 && lg.size() < 16; t++) begin tick_a(); tick_b(); end
    check("cont_cnt", 0, 32'(lg.size()), 32'd16);
    for (int k = 0; k < 16 && k < lg.size(); k++) begin
      int p, w;
      p = k / 4; w = k % 4;
      check("cont_src", k, 32'(lg[k].src), 32'(p % 2));
      check("cont_data", k, lg[k].d, ((p % 2) != 0 ? 32'hD0 : 32'hC0) + 32'((p / 2) * 4 + w));
      check("cont_last", k, 32'(lg[k].last), 32'(w == 3));
      check("cont_cyc", k, 32'(lg[k].cyc), 32'(p * 5 + 1 + w));
    end

    // Granted FIFO runs dry mid-packet while the other one waits.
    do_reset();
    q0.push_back(32'hE0); q0.push_back(32'hE1);
    for (int i = 0; i < 4; i++) q1.push_back(32'h100 + 32'(i));
    gate = 2'b11;
    for (int t = 0; t < 20 && lg.size() < 2; t++) begin tick_a(); tick_b(); end
    check("dry_cnt", 0, 32'(lg.size()), 32'd2);
    for (int s = 0; s < 3; s++) begin
      tick_a();
      check("dry_v", s, 32'(bus.v_o), 32'd0);
      check("dry_busy", s, 32'(bus.busy_o), 32'd1);
      check("dry_src", s, 32'(bus.src_id_o), 32'd0);
      check("dry_yumi", s, 32'(bus.fifo_yumi_o), 32'd0);
      tick_b();
    end
    q0.push_back(32'hE2); q0.push_back(32'hE3);
    for (int t = 0; t < 30 && lg.size() < 8; t++) begin tick_a(); tick_b(); end
    check("dry_total", 0, 32'(lg.size()), 32'd8);
    for (int k = 0; k < 8 && k < lg.size(); k++) begin
      check("dry_osrc", k, 32'(lg[k].src), 32'(k / 4));
      check("dry_odata", k, lg[k].d, (k < 4) ? 32'hE0 + 32'(k) : 32'h100 + 32'(k - 4));
      check("dry_olast", k, 32'(lg[k].last), 32'(k % 4 == 3));
    end

    // FIFO 0 disabled, then reset mid-packet and re-enable.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(32'h200 + 32'(i));
      q1.push_back(32'h300 + 32'(i));
    end
    en = 2'b10; gate = 2'b11;
    for (int t = 0; t < 40 && lg.size() < 6; t++) begin tick_a(); tick_b(); end
    check("dis_cnt", 0, 32'(lg.size()), 32'd6);
    for (int k = 0; k < 6 && k < lg.size(); k++) check("dis_src", k, 32'(lg[k].src), 32'd1);
    check("dis_q0", 0, 32'(q0.size()), 32'd8);
    rst_n = 1'b0;
    tick_a();
    check("pre_rst_tc", 0, 32'(bus.isr_tc_o), 32'd2);
    tick_b();
    rst_n = 1'b1; en = 2'b11;
    tick_a();
    check("rst_v", 0, 32'(bus.v_o), 32'd0);
    check("rst_busy", 0, 32'(bus.busy_o), 32'd0);
    check("rst_tc", 0, 32'(bus.isr_tc_o), 32'd0);
    tick_b();
    tick_a();
    check("re_v", 0, 32'(bus.v_o), 32'd1);
    check("re_src", 0, 32'(bus.src_id_o), 32'd0);
    check("re_data", 0, bus.data_o, 32'h200);
    tick_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
